// File: rtl/spi_dac_seq.sv
// spi_dac_seq: FIFO-buffered SPI word sequencer for serial DACs (MSB first,
// DAC samples DIN on SCLK fall, nSYNC frames each word).
// Ports: clk_i, rst_ni (async, active-low); wr_en_i/wr_data_i enqueue a word;
// full_o, level_o (queued words), busy_o, done_o (end-of-frame pulse),
// ovf_o (sticky drop flag); dac_sclk_o, dac_din_o, dac_nsync_o serial bus.
module spi_dac_seq #(
   parameter int DATA_W     = 16,
   parameter int SCLK_DIV   = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int SYNC_GAP   = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          wr_en_i,
   input  logic [DATA_W-1:0]             wr_data_i,
   output logic                          full_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          ovf_o,
   output logic                          dac_sclk_o,
   output logic                          dac_din_o,
   output logic                          dac_nsync_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DIV_W = $clog2(2 * SCLK_DIV);
   localparam int BIT_W = $clog2(DATA_W);
   localparam int GAP_W = $clog2(SYNC_GAP + 1);

   localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FIFO_DEPTH);
   localparam logic [DIV_W-1:0] DIV_HI   = DIV_W'(SCLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wptr_q, rptr_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_q;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                sclk_q, sclk_d;
   logic                din_q, din_d;
   logic                nsync_q, nsync_d;
   logic                done_q, done_d;
   logic                full, push, pop;

   assign full = (cnt_q == DEPTH);
   assign push = wr_en_i && !full;
   // The only pop happens in LOAD, which is entered only with a word queued.
   assign pop  = (state_q == LOAD);

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         if (wr_en_i && full) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Bus registers are computed from the current state, so the bus
   // trails the state by one cycle: LOAD shows nSYNC low one edge later.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      div_d   = div_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      sclk_d  = 1'b1;
      din_d   = 1'b0;
      nsync_d = 1'b1;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cnt_q != '0) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            sh_d    = mem_q[rptr_q];
            din_d   = mem_q[rptr_q][DATA_W-1];
            nsync_d = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            nsync_d = 1'b0;
            din_d   = sh_q[DATA_W-1];
            sclk_d  = (div_q < DIV_HI);
            if (div_q == DIV_LAST) begin
               div_d = '0;
               sh_d  = sh_q << 1;
               bit_d = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  gap_d   = '0;
                  state_d = GAP;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         GAP: begin
            done_d = (gap_q == '0);
            if (gap_q == GAP_LAST) begin
               state_d = (cnt_q != '0) ? LOAD : IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         sh_q    <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         sclk_q  <= 1'b1;
         din_q   <= 1'b0;
         nsync_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         sclk_q  <= sclk_d;
         din_q   <= din_d;
         nsync_q <= nsync_d;
         done_q  <= done_d;
      end
   end

   assign full_o      = full;
   assign level_o     = cnt_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign ovf_o       = ovf_q;
   assign dac_sclk_o  = sclk_q;
   assign dac_din_o   = din_q;
   assign dac_nsync_o = nsync_q;

endmodule

// File: tb/tb_spi_dac_seq.sv
// tb_spi_dac_seq: directed test of spi_dac_seq, default build (u_a) and
// a 24-bit, SCLK_DIV=1 build (u_b); serial bus decoded by a monitor.
module tb_spi_dac_seq;

   logic        clk;
   logic        rst_n;
   logic        wr_en_a, wr_en_b;
   logic [15:0] wr_data_a;
   logic [23:0] wr_data_b;
   logic        full_a, full_b, busy_a, busy_b, done_a, done_b;
   logic        ovf_a, ovf_b;
   logic [2:0]  level_a, level_b;
   logic [1:0]  sclk_v, din_v, nsync_v, done_v, busy_v;

   int checks = 0;
   int failures = 0;

   spi_dac_seq #(
      .DATA_W(16), .SCLK_DIV(2), .FIFO_DEPTH(4), .SYNC_GAP(2)
   ) u_a (
      .clk_i(clk), .rst_ni(rst_n),
      .wr_en_i(wr_en_a), .wr_data_i(wr_data_a),
      .full_o(full_a), .level_o(level_a), .busy_o(busy_a),
      .done_o(done_a), .ovf_o(ovf_a),
      .dac_sclk_o(sclk_v[0]), .dac_din_o(din_v[0]),
      .dac_nsync_o(nsync_v[0])
   );

   spi_dac_seq #(
      .DATA_W(24), .SCLK_DIV(1), .FIFO_DEPTH(4), .SYNC_GAP(2)
   ) u_b (
      .clk_i(clk), .rst_ni(rst_n),
      .wr_en_i(wr_en_b), .wr_data_i(wr_data_b),
      .full_o(full_b), .level_o(level_b), .busy_o(busy_b),
      .done_o(done_b), .ovf_o(ovf_b),
      .dac_sclk_o(sclk_v[1]), .dac_din_o(din_v[1]),
      .dac_nsync_o(nsync_v[1])
   );

   assign done_v = {done_b, done_a};
   assign busy_v = {busy_b, busy_a};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // bus monitor state, per instance
   logic [31:0] sh [2];
   logic [31:0] lw [2];
   int falls [2];
   int low [2];
   int hi [2];
   int dones [2];
   int nf [2];
   int lfalls [2];
   int llow [2];
   int pmin [2];
   int pmax [2];
   int lf [2];
   logic ps [2];
   logic pn [2];
   int cyc = 0;
   logic [31:0] wq [$];
   int gq [$];
   int lq [$];

   initial begin
      for (int i = 0; i < 2; i++) begin
         sh[i] = 0; lw[i] = 0; falls[i] = 0; low[i] = 0;
         hi[i] = 0; dones[i] = 0; nf[i] = 0; lfalls[i] = 0;
         llow[i] = 0; pmin[i] = 1000; pmax[i] = 0; lf[i] = 0;
         ps[i] = 1'b1; pn[i] = 1'b1;
      end
   end

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            sh[i] = 0; falls[i] = 0; low[i] = 0; hi[i] = 0;
         end else begin
            if (done_v[i]) dones[i]++;
            if (!nsync_v[i]) begin
               if (pn[i]) begin
                  falls[i] = 0; sh[i] = 0; low[i] = 0;
                  pmin[i] = 1000; pmax[i] = 0;
                  if (i == 0) begin
                     gq.push_back(hi[0]);
                     lq.push_back(int'(level_a));
                  end
               end
               low[i]++;
               if (ps[i] && !sclk_v[i]) begin
                  sh[i] = {sh[i][30:0], din_v[i]};
                  if (falls[i] > 0) begin
                     if (cyc - lf[i] < pmin[i]) pmin[i] = cyc - lf[i];
                     if (cyc - lf[i] > pmax[i]) pmax[i] = cyc - lf[i];
                  end
                  lf[i] = cyc;
                  falls[i]++;
               end
            end else begin
               if (!pn[i]) begin
                  nf[i]++;
                  lw[i] = sh[i];
                  lfalls[i] = falls[i];
                  llow[i] = low[i];
                  if (i == 0) wq.push_back(sh[0]);
                  hi[i] = 0;
               end
               hi[i]++;
            end
         end
         ps[i] = rst_n ? sclk_v[i] : 1'b1;
         pn[i] = rst_n ? nsync_v[i] : 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr_a(input logic [15:0] d);
      @(negedge clk);
      wr_en_a = 1'b1;
      wr_data_a = d;
      @(posedge clk);
      #1;
      wr_en_a = 1'b0;
   endtask

   task automatic wait_idle(input int i, input int maxc);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      while (busy_v[i] && n < maxc) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy_v[i]) chk("idle_timeout", 32'd1, 32'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   int n;
   int d0;
   int f0;
   logic [31:0] exp_w [5];

   initial begin
      rst_n = 1'b0;
      wr_en_a = 1'b0; wr_data_a = '0;
      wr_en_b = 1'b0; wr_data_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_level", 32'(level_a), 0);
      chk("rst_full", 32'(full_a), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_done", 32'(done_a), 0);
      chk("rst_ovf", 32'(ovf_a), 0);
      chk("rst_sclk", 32'(sclk_v[0]), 1);
      chk("rst_nsync", 32'(nsync_v[0]), 1);
      chk("rst_din", 32'(din_v[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 24-bit build, SCLK_DIV=1
      @(negedge clk);
      wr_en_b = 1'b1;
      wr_data_b = 24'h800001;
      @(posedge clk);
      #1;
      wr_en_b = 1'b0;
      wait_idle(1, 200);
      chk("b_frames", nf[1], 1);
      chk("b_word", lw[1], 32'h00800001);
      chk("b_falls", lfalls[1], 24);
      chk("b_low", llow[1], 49);
      chk("b_pmin", pmin[1], 2);
      chk("b_pmax", pmax[1], 2);
      chk("b_done", dones[1], 1);

      // single word and write-to-nSYNC latency
      wr_a(16'hA5C3);
      chk("a1_level", 32'(level_a), 1);
      @(posedge clk);
      #1;
      chk("a1_nsync_t1", 32'(nsync_v[0]), 1);
      chk("a1_busy_t1", 32'(busy_a), 1);
      @(posedge clk);
      #1;
      chk("a1_nsync_t2", 32'(nsync_v[0]), 0);
      wait_idle(0, 500);
      chk("a1_frames", nf[0], 1);
      chk("a1_word", lw[0], 32'h0000A5C3);
      chk("a1_falls", lfalls[0], 16);
      chk("a1_low", llow[0], 65);
      chk("a1_period", pmax[0], 4);
      chk("a1_done", dones[0], 1);
      chk("a1_busy", 32'(busy_a), 0);

      // burst of four behind a frame in flight, fifth dropped
      wq.delete();
      gq.delete();
      lq.delete();
      wr_a(16'hFFFF);
      n = 0;
      while (nsync_v[0] && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("burst_start", 32'(nsync_v[0]), 0);
      for (int k = 1; k <= 4; k++) begin
         wr_a(16'(k));
         chk("burst_level", 32'(level_a), 32'(k));
      end
      chk("burst_full", 32'(full_a), 1);
      wr_a(16'h0005);
      chk("ovf_set", 32'(ovf_a), 1);
      chk("ovf_level", 32'(level_a), 4);
      chk("ovf_full", 32'(full_a), 1);
      wait_idle(0, 2000);
      exp_w[0] = 32'hFFFF;
      exp_w[1] = 32'h1;
      exp_w[2] = 32'h2;
      exp_w[3] = 32'h3;
      exp_w[4] = 32'h4;
      chk("burst_nframes", wq.size(), 5);
      if (wq.size() == 5 && gq.size() == 5 && lq.size() == 5) begin
         for (int k = 0; k < 5; k++) chk("burst_word", wq[k], exp_w[k]);
         for (int k = 1; k < 5; k++) begin
            chk("burst_gap", gq[k], 2);
            chk("burst_lvl", lq[k], 32'(4 - k));
         end
      end
      chk("burst_done", dones[0], 6);
      chk("ovf_sticky", 32'(ovf_a), 1);
      chk("burst_level0", 32'(level_a), 0);
      chk("burst_full0", 32'(full_a), 0);

      // reset at bit 7
      wr_a(16'h5A5A);
      n = 0;
      while (!(nsync_v[0] == 1'b0 && falls[0] == 7) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("mid_reached", falls[0], 7);
      d0 = dones[0];
      f0 = nf[0];
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_sclk", 32'(sclk_v[0]), 1);
      chk("mid_nsync", 32'(nsync_v[0]), 1);
      chk("mid_din", 32'(din_v[0]), 0);
      chk("mid_busy", 32'(busy_a), 0);
      chk("mid_level", 32'(level_a), 0);
      chk("mid_ovf", 32'(ovf_a), 0);
      chk("mid_done", 32'(done_a), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("post_done", dones[0], d0);
      chk("post_frames", nf[0], f0);
      chk("post_busy", 32'(busy_a), 0);
      chk("post_nsync", 32'(nsync_v[0]), 1);
      wr_a(16'h3C96);
      wait_idle(0, 500);
      chk("post2_frames", nf[0], f0 + 1);
      chk("post2_word", lw[0], 32'h00003C96);
      chk("post2_falls", lfalls[0], 16);
      chk("post2_low", llow[0], 65);
      chk("post2_done", dones[0], d0 + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_dac_seq.md
SPI_DAC_SEQ -- requirements
Module: spi_dac_seq

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, the serial word length in bits (minimum 8).
REQ-002 SHALL provide parameter SCLK_DIV, default 2, the number of CLK cycles per SCLK half-period (minimum 1).
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4, the number of queued words (power of two, minimum 2).
REQ-004 SHALL provide parameter SYNC_GAP, default 2, the number of CLK cycles nSYNC stays high between frames (minimum 1).
REQ-005 CLK  input  1  single system clock; all logic on the rising edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 WR_EN  input  1  single-cycle request to enqueue WR_DATA.
REQ-008 WR_DATA  input  DATA_W  word to transmit, MSB first.
REQ-009 FULL  output  1  FIFO holds FIFO_DEPTH words.
REQ-010 LEVEL  output  clog2(FIFO_DEPTH)+1  number of queued words, excluding the word in flight.
REQ-011 BUSY  output  1  high whenever the state is not IDLE.
REQ-012 DONE  output  1  one-cycle pulse at the end of each frame.
REQ-013 OVF  output  1  sticky flag: a write was dropped.
REQ-014 DAC_SCLK, DAC_DIN, DAC_nSYNC  output  1 each  serial DAC bus; all driven from registers.

Function
REQ-015 A write SHALL be accepted when WR_EN=1 and FULL=0; LEVEL increments on the following cycle.
REQ-016 WR_EN=1 with FULL=1 SHALL drop the word and set OVF, even if a pop occurs in the same cycle.
REQ-017 A simultaneous accepted write and pop SHALL leave LEVEL unchanged; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The FSM SHALL have states IDLE, LOAD, SHIFT and GAP.
REQ-019 IDLE -> LOAD when LEVEL>0; LOAD SHALL pop one word into the shift register, drive nSYNC=0 and DIN=word MSB, and last exactly one cycle.
REQ-020 In SHIFT, each bit SHALL occupy 2*SCLK_DIV cycles: SCLK high for SCLK_DIV cycles, then low for SCLK_DIV cycles.
REQ-021 DIN SHALL change only at bit-period start (SCLK rising) and SHALL be stable across the SCLK falling edge, which is where the DAC samples.
REQ-022 After DATA_W bit periods, SCLK SHALL return high and nSYNC SHALL go high; the FSM enters GAP and pulses DONE for one cycle.
REQ-023 nSYNC SHALL be low for exactly 1 + DATA_W*2*SCLK_DIV cycles per frame, with exactly DATA_W SCLK falling edges while low.
REQ-024 GAP SHALL last SYNC_GAP cycles, then go to LOAD if LEVEL>0, otherwise to IDLE.
REQ-025 A write to an empty, idle block on edge t SHALL cause nSYNC to fall on edge t+2.
REQ-026 Writes during SHIFT or GAP SHALL NOT disturb the frame in flight.
REQ-027 Idle bus levels SHALL be SCLK=1, nSYNC=1, DIN=0.
REQ-028 Bit and divider counters SHALL be sized from the parameters; there SHALL be no overflow at the maximum parameter values.

Reset
REQ-029 RST_N=0 SHALL immediately force: state=IDLE, FIFO empty, LEVEL=0, FULL=0, BUSY=0, DONE=0, OVF=0, SCLK=1, nSYNC=1, DIN=0.
REQ-030 Reset mid-frame SHALL abort the frame with no DONE pulse; after release, no transmission occurs until a new write.
REQ-031 OVF SHALL clear only on reset.

Verification (DATA_W=16, SCLK_DIV=2, FIFO_DEPTH=4, SYNC_GAP=2 unless stated)
REQ-032 Single write of 0xA5C3 -> DIN sampled on 16 SCLK falls = 1010010111000011, nSYNC low for 65 cycles, exactly one DONE, BUSY returns to 0.
REQ-033 Four back-to-back writes 0x0001..0x0004 -> FULL asserts as required by REQ-015, four frames in order, nSYNC high exactly 2 cycles between frames, LEVEL steps 4..0.
REQ-034 Fifth write while FULL -> word never transmitted, OVF=1 and stays 1, the other four frames are intact.
REQ-035 RST_N low at bit 7 of a frame -> outputs go to idle levels within the reset cycle, no DONE; the next write yields a complete, correct frame.
REQ-036 SCLK_DIV=1, DATA_W=24, write 0x800001 -> 24 falls, SCLK period 2 cycles, first and last sampled bits =1, nSYNC low 49 cycles.
